iir_coeff_ctrl: RTL and testbench
=================================

// Module: iir_coeff_ctrl
// PURPOSE
//  Coefficient bank controller for the configurable IIR filter (FIR feedforward + iir_fb feedback).
//  Host writes b/a coefficients into a shadow bank over a valid/ready port.
//  A commit request swaps the shadow bank into the active bank atomically on a sample boundary.
//  After the swap it issues a synchronous clear so the filter delay lines restart from zero.
// PARAMETERS
//  N            3   number of feedforward (b) coefficients
//  M            2   number of feedback (a) coefficients; matches iir_fb M
//  COEFF_WIDTH  16  coefficient width, signed two's complement
//  COEFF_FRAC   14  fractional bits; reset value of b[0] = 1<<COEFF_FRAC (pass-through)
//  FLUSH_CYCLES 4   filt_clr_n low time after swap; 0 = no flush
//  ADDR_W       4   write address width; N+M <= 2**ADDR_W
// PORTS
//  clk              in   1               clock
//  rst_n            in   1               reset, asynchronous, active-low
//  wr_valid         in   1               coefficient write request
//  wr_ready         out  1               write accepted when wr_valid & wr_ready
//  wr_addr          in   ADDR_W          0..N-1 -> b[addr]; N..N+M-1 -> a[addr-N]
//  wr_data          in   COEFF_WIDTH     coefficient value
//  commit           in   1               single-cycle pulse: request bank swap
//  sample_en        in   1               sample strobe; swap point
//  packed_b_coeffs  out  COEFF_WIDTH*N   active b bank, b[k] at [COEFF_WIDTH*k +: COEFF_WIDTH]
//  packed_a_coeffs  out  COEFF_WIDTH*M   active a bank, same packing; feeds iir_fb
//  filt_clr_n       out  1               synchronous clear to filter delay lines, active-low
//  swapped          out  1               one-cycle pulse on the cycle after the active bank updates
//  busy             out  1               high in ARMED or FLUSH
//  err              out  1               sticky: out-of-range write seen since last commit
// BEHAVIOUR
//  Reset: active b[0]=1<<COEFF_FRAC, other active b/a = 0; shadow = copy of active;
//   state IDLE, wr_ready=1, filt_clr_n=1, swapped=0, busy=0, err=0.
//  States:
//   IDLE:  wr_ready=1. Accepted write updates shadow[wr_addr] at the clock edge.
//          commit -> ARMED, err cleared.
//   ARMED: wr_ready=0, busy=1. On a cycle with sample_en=1, active<=shadow at that edge.
//          Next state FLUSH if FLUSH_CYCLES>0, else IDLE. swapped=1 in the following cycle.
//   FLUSH: filt_clr_n=0 for exactly FLUSH_CYCLES cycles (down-counter), then IDLE.
//  Write and commit in the same IDLE cycle: the write lands in shadow before the swap is armed.
//  Out-of-range write (addr >= N+M): handshake completes, data discarded, err set.
//  commit in ARMED/FLUSH is ignored; no queuing.
//  commit and sample_en in the same IDLE cycle: enter ARMED; swap waits for the next sample_en.
//  Shadow persists after a swap. Partial reload edits only the written taps.
//  Active-bank outputs change only at the swap edge, never mid-sample. All outputs registered.
//  Reset mid-operation (any state): return to reset values immediately; pending commit lost.
//  Latency: commit to swap edge = cycles until the first sample_en after ARMED is entered.
//   swap edge to filt_clr_n low = 1 cycle.
// STRUCTURE
//  Package iir_pkg: state encoding (IDLE/ARMED/FLUSH), coefficient field helper
//   (tap index -> bit slice), unity constant (1<<COEFF_FRAC).
//  Sub-module coeff_bank: N+M-entry register bank, reset value per entry, write port, parallel load.
//   Instantiated twice (shadow, active). FSM and flush counter live in this top.
// TESTING
//  Reset -> packed_b_coeffs b0=16'h4000, others 0; packed_a_coeffs=0; wr_ready=1; filt_clr_n=1.
//  Write a0=16'hC000 (addr 3), commit, sample_en 5 cycles later -> a0 updates on that edge only;
//   swapped pulses once; filt_clr_n low exactly 4 cycles; then busy=0.
//  wr_valid held in ARMED -> wr_ready=0, shadow unchanged; extra commit ignored; one swap total.
//  Write addr 7 (N+M=5) -> accepted, no bank change, err=1. Next commit clears err.
//  Write+commit same cycle with addr 0=16'h2000 -> swapped bank contains b0=16'h2000.
//  rst_n low during FLUSH -> filt_clr_n=1, state IDLE, active back to reset values.
//  FLUSH_CYCLES=0 build -> IDLE directly after swap; filt_clr_n never low.

Source files
------------

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared state encoding and coefficient helpers for the IIR coefficient controller
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLUSH = 2'd2
  } state_t;

  function automatic int tap_lsb(input int tap, input int width);
    return tap * width;
  endfunction

  function automatic logic [31:0] unity(input int frac);
    return 32'd1 << frac;
  endfunction

endpackage

// File: rtl/iir_coeff_ctrl_if.sv
// rtl/iir_coeff_ctrl_if.sv - host coefficient write port (valid/ready)
interface iir_coeff_ctrl_if #(
  parameter int ADDR_W      = 4,
  parameter int COEFF_WIDTH = 16
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [COEFF_WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/iir_coeff_ctrl_coeff_bank.sv
// rtl/iir_coeff_ctrl_coeff_bank.sv - coefficient register bank with write port and parallel load
module coeff_bank
  import iir_pkg::*;
#(
  parameter int ENTRIES     = 5,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14,
  parameter int ADDR_W      = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [ADDR_W-1:0]              waddr,
  input  logic [COEFF_WIDTH-1:0]         wdata,
  input  logic                           load,
  input  logic [ENTRIES*COEFF_WIDTH-1:0] load_data,
  output logic [ENTRIES*COEFF_WIDTH-1:0] q
);

  // Entry 0 resets to unity gain so an unconfigured filter passes samples through.
  localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(unity(COEFF_FRAC));
  localparam logic [ENTRIES*COEFF_WIDTH-1:0] RESET_Q = (ENTRIES*COEFF_WIDTH)'(UNITY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_Q;
    end else if (load) begin
      q <= load_data;
    end else if (we) begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (waddr == ADDR_W'(k)) q[tap_lsb(k, COEFF_WIDTH) +: COEFF_WIDTH] <= wdata;
      end
    end
  end

endmodule

// File: rtl/iir_coeff_ctrl.sv
// rtl/iir_coeff_ctrl.sv - shadow/active IIR coefficient banks with sample-aligned swap and delay-line flush
module iir_coeff_ctrl
  import iir_pkg::*;
#(
  parameter int N            = 3,
  parameter int M            = 2,
  parameter int COEFF_WIDTH  = 16,
  parameter int COEFF_FRAC   = 14,
  parameter int FLUSH_CYCLES = 4,
  parameter int ADDR_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  iir_coeff_ctrl_if.slave          wr,
  input  logic                     commit,
  input  logic                     sample_en,
  output logic [COEFF_WIDTH*N-1:0] packed_b_coeffs,
  output logic [COEFF_WIDTH*M-1:0] packed_a_coeffs,
  output logic                     filt_clr_n,
  output logic                     swapped,
  output logic                     busy,
  output logic                     err
);

  localparam int ENTRIES = N + M;
  localparam int CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t                         state;
  logic                           ready_q;
  logic [CNT_W-1:0]               cnt;
  logic [ENTRIES*COEFF_WIDTH-1:0] shadow_q;
  logic [ENTRIES*COEFF_WIDTH-1:0] active_q;
  logic                           wr_fire;
  logic                           in_range;
  logic                           swap_now;

  assign wr.wr_ready = ready_q;
  assign wr_fire     = wr.wr_valid & ready_q;
  assign in_range    = {1'b0, wr.wr_addr} < (ADDR_W+1)'(ENTRIES);
  assign swap_now    = (state == ARMED) & sample_en;

  coeff_bank #(
    .ENTRIES(ENTRIES), .COEFF_WIDTH(COEFF_WIDTH), .COEFF_FRAC(COEFF_FRAC), .ADDR_W(ADDR_W)
  ) u_shadow (
    .clk(clk), .rst_n(rst_n),
    .we(wr_fire), .waddr(wr.wr_addr), .wdata(wr.wr_data),
    .load(1'b0), .load_data('0),
    .q(shadow_q)
  );

  coeff_bank #(
    .ENTRIES(ENTRIES), .COEFF_WIDTH(COEFF_WIDTH), .COEFF_FRAC(COEFF_FRAC), .ADDR_W(ADDR_W)
  ) u_active (
    .clk(clk), .rst_n(rst_n),
    .we(1'b0), .waddr('0), .wdata('0),
    .load(swap_now), .load_data(shadow_q),
    .q(active_q)
  );

  assign packed_b_coeffs = active_q[COEFF_WIDTH*N-1:0];
  assign packed_a_coeffs = active_q[COEFF_WIDTH*ENTRIES-1:COEFF_WIDTH*N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      filt_clr_n <= 1'b1;
      swapped    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      cnt        <= '0;
    end else begin
      swapped <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_fire && !in_range) err <= 1'b1;
          // A commit clears err even if this cycle's write was out of range.
          if (commit) begin
            state   <= ARMED;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            err     <= 1'b0;
          end
        end
        ARMED: begin
          if (sample_en) begin
            swapped <= 1'b1;
            if (FLUSH_CYCLES > 0) begin
              state      <= FLUSH;
              filt_clr_n <= 1'b0;
              cnt        <= CNT_W'(FLUSH_CYCLES - 1);
            end else begin
              state   <= IDLE;
              ready_q <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            state      <= IDLE;
            filt_clr_n <= 1'b1;
            ready_q    <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          ready_q    <= 1'b1;
          filt_clr_n <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coeff_ctrl.sv
// tb/tb_iir_coeff_ctrl.sv - checks iir_coeff_ctrl (FLUSH_CYCLES 4 and 0) against a behavioural bank model
module tb_iir_coeff_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic commit;
  logic sample_en;

  always #5 clk = ~clk;

  iir_coeff_ctrl_if #(.ADDR_W(4), .COEFF_WIDTH(16)) wr ();
  iir_coeff_ctrl_if #(.ADDR_W(4), .COEFF_WIDTH(16)) wr0 ();

  assign wr0.wr_valid = wr.wr_valid;
  assign wr0.wr_addr  = wr.wr_addr;
  assign wr0.wr_data  = wr.wr_data;

  logic [47:0] pb4, pb0;
  logic [31:0] pa4, pa0;
  logic clr4, clr0, swp4, swp0, busy4, busy0, err4, err0;

  iir_coeff_ctrl #(.FLUSH_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr.slave), .commit(commit), .sample_en(sample_en),
    .packed_b_coeffs(pb4), .packed_a_coeffs(pa4), .filt_clr_n(clr4),
    .swapped(swp4), .busy(busy4), .err(err4)
  );

  iir_coeff_ctrl #(.FLUSH_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(wr0.slave), .commit(commit), .sample_en(sample_en),
    .packed_b_coeffs(pb0), .packed_a_coeffs(pa0), .filt_clr_n(clr0),
    .swapped(swp0), .busy(busy0), .err(err0)
  );

  // Model: five taps (b0..b2, a0..a1), an armed flag and remaining flush cycles.
  typedef struct packed {
    logic [4:0][15:0] sh;
    logic [4:0][15:0] act;
    logic             armed;
    logic [7:0]       fl;
    logic             swp;
    logic             err;
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    m.sh[0]  = 16'h4000;
    m.act[0] = 16'h4000;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t mi, input int f, input logic v,
                                    input logic [3:0] a, input logic [15:0] d,
                                    input logic c, input logic s);
    mdl_t m;
    m = mi;
    m.swp = 1'b0;
    if (m.armed) begin
      if (s) begin
        m.act   = m.sh;
        m.swp   = 1'b1;
        m.armed = 1'b0;
        m.fl    = 8'(f);
      end
    end else if (m.fl != 0) begin
      m.fl = m.fl - 8'd1;
    end else begin
      if (v) begin
        if (a < 4'd5) m.sh[a[2:0]] = d;
        else m.err = 1'b1;
      end
      if (c) begin
        m.armed = 1'b1;
        m.err   = 1'b0;
      end
    end
    return m;
  endfunction

  mdl_t m4, m0;
  int n_chk = 0;
  int n_fail = 0;
  int low4 = 0, low0 = 0, pulses4 = 0, pulses0 = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= mdl_reset();
      m0 <= mdl_reset();
    end else begin
      m4 <= mdl_step(m4, 4, wr.wr_valid, wr.wr_addr, wr.wr_data, commit, sample_en);
      m0 <= mdl_step(m0, 0, wr.wr_valid, wr.wr_addr, wr.wr_data, commit, sample_en);
    end
  end

  always @(negedge clk) begin
    chk("b4", 64'(pb4), 64'(m4.act[2:0]));
    chk("a4", 64'(pa4), 64'(m4.act[4:3]));
    chk("clr4", 64'(clr4), 64'(m4.fl == 0));
    chk("swp4", 64'(swp4), 64'(m4.swp));
    chk("busy4", 64'(busy4), 64'(m4.armed || m4.fl != 0));
    chk("rdy4", 64'(wr.wr_ready), 64'(!(m4.armed || m4.fl != 0)));
    chk("err4", 64'(err4), 64'(m4.err));
    chk("b0", 64'(pb0), 64'(m0.act[2:0]));
    chk("a0", 64'(pa0), 64'(m0.act[4:3]));
    chk("clr0", 64'(clr0), 64'(m0.fl == 0));
    chk("swp0", 64'(swp0), 64'(m0.swp));
    chk("busy0", 64'(busy0), 64'(m0.armed || m0.fl != 0));
    chk("rdy0", 64'(wr0.wr_ready), 64'(!(m0.armed || m0.fl != 0)));
    chk("err0", 64'(err0), 64'(m0.err));
    if (!clr4) low4++;
    if (!clr0) low0++;
    if (swp4) pulses4++;
    if (swp0) pulses0++;
  end

  task automatic cyc(input logic v, input logic [3:0] a, input logic [15:0] d,
                     input logic c, input logic s);
    wr.wr_valid = v;
    wr.wr_addr  = a;
    wr.wr_data  = d;
    commit      = c;
    sample_en   = s;
    @(posedge clk);
    #1;
    wr.wr_valid = 1'b0;
    commit      = 1'b0;
    sample_en   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b0);
  endtask

  int l_start, p_start;

  initial begin
    rst_n = 1'b0;
    wr.wr_valid = 1'b0;
    wr.wr_addr = '0;
    wr.wr_data = '0;
    commit = 1'b0;
    sample_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_b", 64'(pb4), 64'h0000_0000_4000);
    chk("rst_a", 64'(pa4), 64'h0);
    chk("rst_rdy", 64'(wr.wr_ready), 64'h1);
    chk("rst_clr", 64'(clr4), 64'h1);
    rst_n = 1'b1;

    // a0 = C000, commit, sample 5 cycles later
    cyc(1'b1, 4'd3, 16'hC000, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    idle(4);
    chk("a_before_swap", 64'(pa4), 64'h0);
    l_start = low4;
    p_start = pulses4;
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    chk("a_after_swap", 64'(pa4), 64'h0000_C000);
    chk("swp_after_swap", 64'(swp4), 64'h1);
    chk("mdl_a0", 64'(m4.act[3]), 64'hC000);
    idle(8);
    chk("flush_len", 64'(low4 - l_start), 64'd4);
    chk("one_swap", 64'(pulses4 - p_start), 64'd1);
    chk("busy_done", 64'(busy4), 64'h0);

    // Writes and extra commits while armed are refused
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    p_start = pulses4;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 4'd0, 16'h1234, 1'b1, 1'b0);
      chk("armed_rdy", 64'(wr.wr_ready), 64'h0);
    end
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    idle(8);
    chk("armed_one_swap", 64'(pulses4 - p_start), 64'd1);
    chk("armed_b0_kept", 64'(pb4[15:0]), 64'h4000);

    // Out-of-range write
    cyc(1'b1, 4'd7, 16'hBEEF, 1'b0, 1'b0);
    chk("oor_err", 64'(err4), 64'h1);
    chk("oor_b", 64'(pb4), 64'h0000_0000_4000);
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 1'b0);
    chk("commit_clr_err", 64'(err4), 64'h0);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    idle(8);

    // Write and commit together
    cyc(1'b1, 4'd0, 16'h2000, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    chk("wc_b0", 64'(pb4[15:0]), 64'h2000);
    idle(8);

    // Commit and sample together: swap waits for next sample
    cyc(1'b0, 4'd0, 16'd0, 1'b1, 1'b1);
    chk("cs_busy", 64'(busy4), 64'h1);
    chk("cs_noswap", 64'(swp4), 64'h0);
    idle(2);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    chk("cs_swap", 64'(swp4), 64'h1);
    idle(8);

    // Reset during flush
    cyc(1'b1, 4'd4, 16'h7777, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 16'd0, 1'b0, 1'b1);
    idle(1);
    chk("in_flush", 64'(clr4), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_flush_clr", 64'(clr4), 64'h1);
    chk("rst_flush_busy", 64'(busy4), 64'h0);
    chk("rst_flush_b", 64'(pb4), 64'h0000_0000_4000);
    chk("rst_flush_a", 64'(pa4), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 16'($urandom),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0));
    end
    idle(10);

    chk("f0_never_low", 64'(low0), 64'd0);
    chk("f0_swapped", 64'(pulses0 > 0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
